// File: rtl/ffq_pkg.sv
// Shared types and constants for the contestant-button receive path.
package ffq_pkg;

    localparam int         NUM_PLAYERS = 10;
    localparam logic [3:0] CODE_NONE_N = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        LOCKED  = 2'd2,
        EXPIRED = 2'd3
    } ffq_state_e;

    // Active-low {g,f,e,d,c,b,a}; element [d] is digit d.
    localparam logic [6:0]       SEG_BLANK_N = 7'h7F;
    localparam logic [9:0][6:0]  SEG_DIGIT_N = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/ffq_seg7_decode.sv
// Player number to active-low 7-segment pattern; player 10 shows "0",
// anything outside 1..10 is blank.
module ffq_seg7_decode
    import ffq_pkg::*;
(
    input  logic [3:0] id_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_BLANK_N;
        if (id_i >= 4'd1 && id_i <= 4'd9) begin
            seg_n_o = SEG_DIGIT_N[id_i];
        end else if (id_i == 4'd10) begin
            seg_n_o = SEG_DIGIT_N[0];
        end
    end

endmodule

// File: rtl/ffq_winner_decoder.sv
// Quiz buzzer receive end: code validation, stability filter, first-press
// lockout, winner display, buzzer pulse and answer timer.
module ffq_winner_decoder
    import ffq_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int BUZZ_CYCLES   = 1000,
    parameter int ANSWER_CYCLES = 50000
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             code_n,
    input  logic                   round_start,
    output logic [NUM_PLAYERS-1:0] winner_led_n,
    output logic [3:0]             winner_id,
    output logic [6:0]             seg_n,
    output logic                   buzzer,
    output logic                   timeout,
    output logic                   armed,
    output logic                   bad_code
);

    localparam int STB_W = $clog2(STABLE_CYCLES + 1);
    localparam int BUZ_W = $clog2(BUZZ_CYCLES + 1);
    localparam int ANS_W = $clog2(ANSWER_CYCLES + 1);

    localparam logic [STB_W-1:0] STB_TARGET = STB_W'(STABLE_CYCLES);
    localparam logic [BUZ_W-1:0] BUZ_LAST   = BUZ_W'(BUZZ_CYCLES - 1);
    localparam logic [ANS_W-1:0] ANS_LAST   = ANS_W'(ANSWER_CYCLES - 1);

    ffq_state_e             state_q, state_d;
    logic [STB_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             prev_n_q, prev_n_d;
    logic [BUZ_W-1:0]       buzz_cnt_q, buzz_cnt_d;
    logic [ANS_W-1:0]       ans_cnt_q, ans_cnt_d;
    logic [3:0]             winner_id_q, winner_id_d;
    logic [NUM_PLAYERS-1:0] led_q, led_d;
    logic [6:0]             seg_q, seg_d;
    logic                   buzzer_q, buzzer_d;
    logic                   timeout_q, timeout_d;
    logic                   armed_q, armed_d;
    logic                   bad_q, bad_d;

    logic [3:0]             n;
    logic                   n_valid;
    logic                   n_bad;
    logic [STB_W-1:0]       filt_cnt;
    logic                   accept;
    logic [6:0]             seg_lock_n;
    logic [NUM_PLAYERS-1:0] led_lock_n;

    assign n       = ~code_n;
    assign n_valid = (code_n != CODE_NONE_N) && (n <= 4'd10);
    assign n_bad   = (n > 4'd10);

    // cnt_q == 0 marks "previous sample was not valid", so a match on n alone is not enough.
    always_comb begin
        filt_cnt = '0;
        if (n_valid) begin
            if (n == prev_n_q && cnt_q != '0) begin
                filt_cnt = (cnt_q == STB_TARGET) ? cnt_q : cnt_q + 1'b1;
            end else begin
                filt_cnt = STB_W'(1);
            end
        end
    end

    assign accept = (state_q == ARMED) && n_valid && (filt_cnt == STB_TARGET);

    always_comb begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            led_lock_n[i] = (n != 4'(i + 1));
        end
    end

    ffq_seg7_decode u_seg7 (
        .id_i    (n),
        .seg_n_o (seg_lock_n)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prev_n_d    = prev_n_q;
        buzz_cnt_d  = buzz_cnt_q;
        ans_cnt_d   = ans_cnt_q;
        winner_id_d = winner_id_q;
        led_d       = led_q;
        seg_d       = seg_q;
        buzzer_d    = buzzer_q;
        timeout_d   = timeout_q;
        bad_d       = 1'b0;

        if (buzzer_q) begin
            if (buzz_cnt_q == BUZ_LAST) begin
                buzzer_d = 1'b0;
            end else begin
                buzz_cnt_d = buzz_cnt_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                prev_n_d = '0;
            end
            ARMED: begin
                cnt_d    = filt_cnt;
                prev_n_d = n;
                bad_d    = n_bad;
                if (accept) begin
                    state_d     = LOCKED;
                    winner_id_d = n;
                    led_d       = led_lock_n;
                    seg_d       = seg_lock_n;
                    buzzer_d    = 1'b1;
                    buzz_cnt_d  = '0;
                    ans_cnt_d   = '0;
                    cnt_d       = '0;
                end
            end
            LOCKED: begin
                if (ans_cnt_q == ANS_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = EXPIRED;
                end else begin
                    ans_cnt_d = ans_cnt_q + 1'b1;
                end
            end
            EXPIRED: begin
                timeout_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Arming overrides everything above, including a same-cycle acceptance.
        if (round_start) begin
            state_d     = ARMED;
            cnt_d       = '0;
            prev_n_d    = '0;
            buzz_cnt_d  = '0;
            ans_cnt_d   = '0;
            winner_id_d = '0;
            led_d       = '1;
            seg_d       = SEG_BLANK_N;
            buzzer_d    = 1'b0;
            timeout_d   = 1'b0;
        end

        armed_d = (state_d == ARMED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prev_n_q    <= '0;
            buzz_cnt_q  <= '0;
            ans_cnt_q   <= '0;
            winner_id_q <= '0;
            led_q       <= '1;
            seg_q       <= SEG_BLANK_N;
            buzzer_q    <= 1'b0;
            timeout_q   <= 1'b0;
            armed_q     <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_n_q    <= prev_n_d;
            buzz_cnt_q  <= buzz_cnt_d;
            ans_cnt_q   <= ans_cnt_d;
            winner_id_q <= winner_id_d;
            led_q       <= led_d;
            seg_q       <= seg_d;
            buzzer_q    <= buzzer_d;
            timeout_q   <= timeout_d;
            armed_q     <= armed_d;
            bad_q       <= bad_d;
        end
    end

    assign winner_led_n = led_q;
    assign winner_id    = winner_id_q;
    assign seg_n        = seg_q;
    assign buzzer       = buzzer_q;
    assign timeout      = timeout_q;
    assign armed        = armed_q;
    assign bad_code     = bad_q;

endmodule

// File: tb/tb_ffq_winner_decoder.sv
// Directed bench for ffq_winner_decoder with short timer parameters.
module tb_ffq_winner_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] code_n;
    logic       round_start;
    logic [9:0] winner_led_n;
    logic [3:0] winner_id;
    logic [6:0] seg_n;
    logic       buzzer;
    logic       timeout;
    logic       armed;
    logic       bad_code;

    int nvec = 0;
    int nmis = 0;

    ffq_winner_decoder #(
        .STABLE_CYCLES (4),
        .BUZZ_CYCLES   (8),
        .ANSWER_CYCLES (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .code_n       (code_n),
        .round_start  (round_start),
        .winner_led_n (winner_led_n),
        .winner_id    (winner_id),
        .seg_n        (seg_n),
        .buzzer       (buzzer),
        .timeout      (timeout),
        .armed        (armed),
        .bad_code     (bad_code)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm();
        round_start = 1'b1;
        tick();
        round_start = 1'b0;
    endtask

    task automatic hold(input logic [3:0] c, input int cycles);
        code_n = c;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check_vec({tag, "_led"},   32'(winner_led_n), 'h3FF);
        check_vec({tag, "_id"},    32'(winner_id),    0);
        check_vec({tag, "_seg"},   32'(seg_n),        'h7F);
        check_vec({tag, "_buzz"},  32'(buzzer),       0);
        check_vec({tag, "_tmo"},   32'(timeout),      0);
        check_vec({tag, "_armed"}, 32'(armed),        0);
        check_vec({tag, "_bad"},   32'(bad_code),     0);
    endtask

    initial begin
        int buzz_hi;
        int tmo_first;
        bit saw3;

        reset       = 1'b1;
        code_n      = 4'hF;
        round_start = 1'b0;
        tick();
        tick();
        check_reset_vals("por");
        reset = 1'b0;
        tick();
        check_vec("idle_armed", 32'(armed), 0);

        // Lock on player 3, then lockout, buzzer length and timeout
        arm();
        check_vec("arm_armed", 32'(armed), 1);
        hold(4'hC, 3);
        check_vec("pre_lock_id", 32'(winner_id), 0);
        hold(4'hC, 1);
        check_vec("lock_id",    32'(winner_id),    3);
        check_vec("lock_led",   32'(winner_led_n), 'h3FB);
        check_vec("lock_seg",   32'(seg_n),        'h30);
        check_vec("lock_armed", 32'(armed),        0);
        buzz_hi   = buzzer ? 1 : 0;
        tmo_first = 0;
        for (int k = 1; k <= 25; k++) begin
            code_n = (k <= 2) ? 4'hC : (k <= 12) ? 4'h6 : 4'hF;
            tick();
            if (buzzer) buzz_hi++;
            if (timeout && tmo_first == 0) tmo_first = k;
            if (k == 12) begin
                check_vec("lockout_id",  32'(winner_id),    3);
                check_vec("lockout_led", 32'(winner_led_n), 'h3FB);
            end
        end
        check_vec("buzz_len",     32'(buzz_hi),   8);
        check_vec("tmo_edge",     32'(tmo_first), 20);
        check_vec("exp_tmo",      32'(timeout),   1);
        check_vec("exp_id_hold",  32'(winner_id), 3);
        check_vec("exp_seg_hold", 32'(seg_n),     'h30);

        // Re-arm from EXPIRED
        arm();
        check_vec("rearm_tmo",   32'(timeout),      0);
        check_vec("rearm_id",    32'(winner_id),    0);
        check_vec("rearm_led",   32'(winner_led_n), 'h3FF);
        check_vec("rearm_seg",   32'(seg_n),        'h7F);
        check_vec("rearm_armed", 32'(armed),        1);

        // Glitch: 3 cycles of player 3 then player 2
        saw3 = 1'b0;
        code_n = 4'hC;
        for (int i = 0; i < 3; i++) begin tick(); if (winner_id == 4'd3) saw3 = 1'b1; end
        code_n = 4'hD;
        for (int i = 0; i < 3; i++) begin tick(); if (winner_id == 4'd3) saw3 = 1'b1; end
        check_vec("glitch_pre", 32'(winner_id), 0);
        tick();
        check_vec("glitch_id",  32'(winner_id), 2);
        check_vec("glitch_no3", 32'(saw3),      0);
        check_vec("glitch_seg", 32'(seg_n),     'h24);
        hold(4'hF, 1);

        // round_start beats a same-cycle acceptance; filter restarts
        arm();
        hold(4'hC, 3);
        round_start = 1'b1;
        tick();
        round_start = 1'b0;
        check_vec("rs_win_id",    32'(winner_id), 0);
        check_vec("rs_win_armed", 32'(armed),     1);
        hold(4'hC, 3);
        check_vec("rs_restart_pre", 32'(winner_id), 0);
        hold(4'hC, 1);
        check_vec("rs_restart_id",  32'(winner_id), 3);
        hold(4'hF, 1);

        // Bad code then player 10
        arm();
        hold(4'h3, 1);
        check_vec("bad_pulse", 32'(bad_code),  1);
        check_vec("bad_nolock", 32'(winner_id), 0);
        hold(4'h5, 1);
        check_vec("bad_clear", 32'(bad_code), 0);
        hold(4'h5, 3);
        check_vec("p10_id",  32'(winner_id),    10);
        check_vec("p10_seg", 32'(seg_n),        'h40);
        check_vec("p10_led", 32'(winner_led_n), 'h1FF);
        hold(4'hF, 1);

        // Asynchronous reset while the buzzer is sounding
        arm();
        hold(4'hC, 4);
        hold(4'hF, 2);
        check_vec("pre_rst_buzz", 32'(buzzer), 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_rst");
        tick();
        reset = 1'b0;
        tick();

        // IDLE ignores codes
        hold(4'hC, 6);
        check_vec("idle_id",    32'(winner_id), 0);
        check_vec("idle_armed2", 32'(armed),    0);
        hold(4'h3, 1);
        check_vec("idle_bad",   32'(bad_code),  0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
